// File: rtl/mem_arbiter_if.sv
// Bundle between the packet-memory arbiter, its requesters and the memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_ce_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*4-1:0]      req_width_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      mem_ce_o;
    logic                      mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [3:0]                mem_width_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic [DATA_W-1:0]         mem_data_i;
    logic [IDX_W-1:0]          owner_o;
    logic                      busy_o;
    logic                      err_o;
    logic [IDX_W-1:0]          err_id_o;

    modport slave (
        input  req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i, mem_data_i,
        output gnt_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output owner_o, busy_o, err_o, err_id_o
    );

    modport master (
        output req_ce_i, req_we_i, req_addr_i, req_width_i, req_data_i, mem_data_i,
        input  gnt_o, rdata_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  owner_o, busy_o, err_o, err_id_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single packet-memory port; grant locks while the owner holds ce.
// Grant 1 cycle after ce; owner's bundle passes through combinationally; others wait for gnt.
module mem_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   owner;
    logic               busy;
    logic               err;
    logic [IDX_W-1:0]   err_id;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    int                 idx;

    // Outside GRANT 'owner' is the last owner, so the scan base is the same register.
    // A releasing owner is masked out so it cannot be regranted at its own release edge.
    always_comb begin
        cand     = bus.req_ce_i;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        if (state == GRANT) cand[owner] = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(owner) + i) % NUM_REQ;
            if (cand[idx]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= IDX_W'(NUM_REQ - 1);
            busy     <= 1'b0;
            err      <= 1'b0;
            err_id   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= GRANT;
                        gnt      <= NUM_REQ'(1) << pick;
                        owner    <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!bus.req_ce_i[owner]) begin
                        hold_cnt <= '0;
                        if (pick_vld) begin
                            gnt   <= NUM_REQ'(1) << pick;
                            owner <= pick;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_W'(MAX_HOLD - 1) && !err) begin
                            err    <= 1'b1;
                            err_id <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, which also zeroes the memory side.
    always_comb begin
        bus.mem_ce_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_width_o = '0;
        bus.mem_data_o  = '0;
        if (state == GRANT) begin
            bus.mem_ce_o    = bus.req_ce_i[owner];
            bus.mem_we_o    = bus.req_we_i[owner] & bus.req_ce_i[owner];
            bus.mem_addr_o  = bus.req_addr_i[int'(owner)*ADDR_W +: ADDR_W];
            bus.mem_width_o = bus.req_width_i[int'(owner)*4 +: 4];
            bus.mem_data_o  = bus.req_data_i[int'(owner)*DATA_W +: DATA_W];
        end
    end

    assign bus.rdata_o  = bus.mem_data_i;
    assign bus.gnt_o    = gnt;
    assign bus.owner_o  = owner;
    assign bus.busy_o   = busy;
    assign bus.err_o    = err;
    assign bus.err_id_o = err_id;
endmodule
